// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Launches with a start/busy handshake, waits for frame done, then holds an inter-frame gap.
module uart_tx_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 16,
   parameter int TIMEOUT    = 4096
) (
   input  logic                       clk_in,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       tx_start,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       frame_sent,
   output logic                       timeout_err,
   output logic                       arb_busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2((TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1);
   localparam logic [ID_W:0] N_W = (ID_W+1)'(N_REQ);

   typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT_DONE, GAP} state_t;
   state_t state, state_nxt;

   logic              busy_s1, busy_s, done_s1, done_s, done_d, done_rise;
   logic [ID_W-1:0]   rr_ptr, pick;
   logic [ID_W:0]     scan_idx;
   logic              found;
   logic [DATA_W-1:0] pick_data;
   logic [CNT_W-1:0]  cnt;
   logic              accept, cnt_clr, to_hit, sent;

   // transmitter status crosses from clk_uart; done_d only feeds the edge detect
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         busy_s1 <= 1'b0;
         busy_s  <= 1'b0;
         done_s1 <= 1'b0;
         done_s  <= 1'b0;
         done_d  <= 1'b0;
      end else begin
         busy_s1 <= tx_busy;
         busy_s  <= busy_s1;
         done_s1 <= tx_done;
         done_s  <= done_s1;
         done_d  <= done_s;
      end
   end

   assign done_rise = done_s & ~done_d;

   // first valid requester at or above the rr pointer, wrapping
   always_comb begin
      pick     = '0;
      found    = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan_idx >= N_W) scan_idx = scan_idx - N_W;
         if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = scan_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      pick_data = '0;
      for (int i = 0; i < N_REQ; i++)
         if (pick == ID_W'(i)) pick_data = req_data[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cnt_clr   = 1'b0;
      to_hit    = 1'b0;
      sent      = 1'b0;
      case (state)
         IDLE:      if (|req_valid) state_nxt = GRANT;
         GRANT:
            if (found) begin
               accept    = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = LAUNCH;
            end else begin
               state_nxt = IDLE;
            end
         LAUNCH:
            if (busy_s) begin
               state_nxt = WAIT_DONE;
            end else if (cnt == CNT_W'(TIMEOUT-1)) begin
               to_hit    = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = GAP;
            end
         WAIT_DONE:
            if (done_rise) begin
               sent      = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = GAP;
            end
         GAP:       if (cnt == CNT_W'(GAP_CYCLES-1)) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign req_ready = accept ? (N_REQ'(1) << pick) : '0;
   assign tx_start  = (state == LAUNCH);
   assign arb_busy  = (state != IDLE);

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         rr_ptr      <= '0;
         grant_id    <= '0;
         tx_data     <= '0;
         frame_sent  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         frame_sent <= sent;
         if (to_hit) timeout_err <= 1'b1;
         if (cnt_clr)
            cnt <= '0;
         else if (state == LAUNCH || state == GAP)
            cnt <= cnt + CNT_W'(1);
         if (accept) begin
            tx_data  <= pick_data;
            grant_id <= pick;
            rr_ptr   <= (pick == ID_W'(N_REQ-1)) ? '0 : pick + ID_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: round-robin model checked every cycle plus directed
// frames with literal grant/data expectations, timeout, and mid-frame reset.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b0;
   logic [3:0]  req_valid = 4'b1111;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        tx_done = 1'b0;
   logic [1:0]  grant_id;
   logic        frame_sent, timeout_err, arb_busy;

   logic [7:0] bytes [4] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
   assign req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

   uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYCLES(16), .TIMEOUT(4096)) dut (
      .clk_in(clk_in), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .tx_done(tx_done), .grant_id(grant_id), .frame_sent(frame_sent),
      .timeout_err(timeout_err), .arb_busy(arb_busy));

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_expired(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // reference model: round robin over the bench's view of the requests
   int         m_rr = 0, m_gid = 0, m_e = 0, n_acc = 0;
   logic [7:0] m_data = '0;
   logic [3:0] m_exp_rdy;
   bit         m_pending = 0;
   logic       prev_terr = 1'b0;

   function automatic int rr_pick(input int rr, input logic [3:0] v);
      int idx;
      for (int k = 0; k < N; k++) begin
         idx = (rr + k) % N;
         if (v[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   always @(negedge clk_in) begin
      if (!reset) begin
         m_rr = 0; m_gid = 0; m_data = '0; m_pending = 0; prev_terr = 1'b0;
      end else begin
         check("grant_id_model", grant_id, m_gid);
         check("tx_data_model", tx_data, m_data);
         if (tx_start) check("busy_in_launch", arb_busy, 1);
         if (timeout_err && !prev_terr) m_pending = 0;
         prev_terr = timeout_err;
         if (frame_sent) begin
            check("frame_sent_legal", m_pending, 1);
            m_pending = 0;
         end
         if (req_ready != 4'b0) begin
            m_e = rr_pick(m_rr, req_valid);
            m_exp_rdy = (m_e < 0) ? 4'b0 : (4'b0001 << m_e);
            check("ready_onehot", req_ready, m_exp_rdy);
            check("one_accept_per_frame", m_pending, 0);
            if (m_e >= 0) begin
               m_gid = m_e;
               m_data = bytes[m_e];
               m_rr = (m_e + 1) % N;
            end
            m_pending = 1;
            n_acc++;
         end
      end
   end

   task automatic wait_start(input string name, output bit ok);
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk_in);
         if (tx_start) begin ok = 1; break; end
      end
      if (!ok) bound_expired(name);
   endtask

   task automatic wait_start_low(input string name, output bit ok);
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_in);
         if (!tx_start) begin ok = 1; break; end
      end
      if (!ok) bound_expired(name);
   endtask

   task automatic wait_sent(input string name, output bit ok);
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_in);
         if (frame_sent) begin ok = 1; break; end
      end
      if (!ok) bound_expired(name);
   endtask

   task automatic do_frame(input int exp_id, input logic [7:0] exp_d);
      bit ok;
      wait_start("launch_wait", ok);
      if (!ok) return;
      check("grant_id_lit", grant_id, exp_id);
      check("tx_data_lit", tx_data, exp_d);
      @(posedge clk_in); #1 tx_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         check("start_held", tx_start, 1);
      end
      @(negedge clk_in);
      check("start_drop", tx_start, 0);
      repeat (2) @(posedge clk_in);
      #1 tx_done = 1'b1; tx_busy = 1'b0;
      wait_sent("frame_wait", ok);
      if (!ok) return;
      check("tx_data_at_done", tx_data, exp_d);
      tx_done = 1'b0;
      @(negedge clk_in);
      check("frame_pulse_1cyc", frame_sent, 0);
   endtask

   initial begin
      bit ok, seen;
      int n, base;
      // reset with all requesters pending
      repeat (3) @(negedge clk_in);
      check("reset_outs", {req_ready, tx_start, tx_data, grant_id, frame_sent, timeout_err, arb_busy}, 0);
      base = n_acc;
      reset = 1'b1;
      do_frame(0, 8'h3C);
      // round robin with all valid
      do_frame(1, 8'hA5);
      do_frame(2, 8'h5A);
      do_frame(3, 8'hC3);
      do_frame(0, 8'h3C);
      check("rr_accept_count", n_acc - base, 5);
      // skip and wrap
      req_valid = 4'b0010;
      do_frame(1, 8'hA5);
      req_valid = 4'b0011;
      do_frame(0, 8'h3C);
      do_frame(1, 8'hA5);
      req_valid = 4'b1000;
      do_frame(3, 8'hC3);
      // timeout: transmitter never goes busy
      req_valid = 4'b0100;
      wait_start("to_launch_wait", ok);
      if (ok) begin
         check("to_grant", grant_id, 2);
         check("to_err_before", timeout_err, 0);
         req_valid = 4'b0001;
         n = 1; seen = 0;
         while (tx_start && n < 5000) begin
            @(negedge clk_in);
            if (frame_sent) seen = 1;
            if (tx_start) n++;
         end
         check("to_launch_cycles", n, 4096);
         check("to_err_set", timeout_err, 1);
         check("to_no_frame", seen, 0);
         do_frame(0, 8'h3C);
         check("to_err_sticky", timeout_err, 1);
      end
      // reset mid-frame, then stale tx_done
      req_valid = 4'b0100;
      wait_start("rst_launch_wait", ok);
      if (ok) begin
         check("rst_grant", grant_id, 2);
         @(posedge clk_in); #1 tx_busy = 1'b1;
         wait_start_low("rst_wait_done", ok);
         #2 reset = 1'b0; tx_busy = 1'b0; tx_done = 1'b1;
         #1 check("async_reset_outs",
                  {req_ready, tx_start, tx_data, grant_id, frame_sent, timeout_err, arb_busy}, 0);
         repeat (2) @(negedge clk_in);
         reset = 1'b1;
         wait_start("stale_launch_wait", ok);
         if (ok) begin
            check("stale_grant", grant_id, 2);
            @(posedge clk_in); #1 tx_busy = 1'b1;
            wait_start_low("stale_wait_done", ok);
            seen = 0;
            repeat (30) begin
               @(negedge clk_in);
               if (frame_sent) seen = 1;
            end
            check("stale_done_ignored", seen, 0);
            tx_done = 1'b0;
            repeat (3) @(posedge clk_in);
            #1 tx_done = 1'b1; tx_busy = 1'b0;
            wait_sent("fresh_done_wait", ok);
            check("fresh_done_sent", ok, 1);
            tx_done = 1'b0;
         end
      end
      repeat (5) @(negedge clk_in);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule
